// File: rtl/id_ex_ctrl_if.sv
// Control bundle between the ID-stage decoder and the EX/MEM/WB control pipe.
// master = decoder side, slave = id_ex_ctrl_pipe.
interface id_ex_ctrl_if #(
  parameter int ALUOP_W    = 3,
  parameter int REG_ADDR_W = 5
);
  logic                  id_regwrite_i;
  logic                  id_memwrite_i;
  logic                  id_memread_i;
  logic                  id_alusrc_i;
  logic [ALUOP_W-1:0]    id_aluop_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_branch_taken_i;

  logic                  stall_o;
  logic                  flush_o;
  logic                  ex_regwrite_o;
  logic                  ex_memwrite_o;
  logic                  ex_memread_o;
  logic                  ex_alusrc_o;
  logic [ALUOP_W-1:0]    ex_aluop_o;
  logic [REG_ADDR_W-1:0] ex_rd_o;
  logic                  mem_regwrite_o;
  logic                  mem_memwrite_o;
  logic                  mem_memread_o;
  logic [REG_ADDR_W-1:0] mem_rd_o;
  logic                  wb_regwrite_o;
  logic                  wb_memtoreg_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;

  modport master (
    output id_regwrite_i, id_memwrite_i, id_memread_i, id_alusrc_i, id_aluop_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_branch_taken_i,
    input  stall_o, flush_o,
           ex_regwrite_o, ex_memwrite_o, ex_memread_o, ex_alusrc_o, ex_aluop_o, ex_rd_o,
           mem_regwrite_o, mem_memwrite_o, mem_memread_o, mem_rd_o,
           wb_regwrite_o, wb_memtoreg_o, wb_rd_o
  );

  modport slave (
    input  id_regwrite_i, id_memwrite_i, id_memread_i, id_alusrc_i, id_aluop_i,
           id_rs1_i, id_rs2_i, id_rd_i, id_branch_taken_i,
    output stall_o, flush_o,
           ex_regwrite_o, ex_memwrite_o, ex_memread_o, ex_alusrc_o, ex_aluop_o, ex_rd_o,
           mem_regwrite_o, mem_memwrite_o, mem_memread_o, mem_rd_o,
           wb_regwrite_o, wb_memtoreg_o, wb_rd_o
  );
endinterface

// File: rtl/id_ex_ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline with load-use stall / bubble insertion and branch-flush gating.
// Optional stall/flush performance counters are enabled by defining CTRL_PERF_CNT_EN.
module id_ex_ctrl_pipe #(
  parameter int ALUOP_W    = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  id_ex_ctrl_if.slave      ctrl
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);
  logic                  hazard;

  logic                  ex_regwrite_reg,  ex_regwrite_next;
  logic                  ex_memwrite_reg,  ex_memwrite_next;
  logic                  ex_memread_reg,   ex_memread_next;
  logic                  ex_alusrc_reg,    ex_alusrc_next;
  logic [ALUOP_W-1:0]    ex_aluop_reg,     ex_aluop_next;
  logic [REG_ADDR_W-1:0] ex_rd_reg,        ex_rd_next;

  logic                  mem_regwrite_reg;
  logic                  mem_memwrite_reg;
  logic                  mem_memread_reg;
  logic [REG_ADDR_W-1:0] mem_rd_reg;

  logic                  wb_regwrite_reg;
  logic                  wb_memtoreg_reg;
  logic [REG_ADDR_W-1:0] wb_rd_reg;

  // Only a load sitting in EX can stall; x0 is never a real dependency.
  // rs2 is compared even for I-type, accepting the occasional false stall.
  always_comb begin
    hazard = ex_memread_reg & (ex_rd_reg != '0) &
             ((ex_rd_reg == ctrl.id_rs1_i) | (ex_rd_reg == ctrl.id_rs2_i));
  end

  always_comb begin
    ex_regwrite_next = 1'b0;
    ex_memwrite_next = 1'b0;
    ex_memread_next  = 1'b0;
    ex_alusrc_next   = 1'b0;
    ex_aluop_next    = '0;
    ex_rd_next       = '0;
    if (!hazard) begin
      ex_regwrite_next = ctrl.id_regwrite_i;
      ex_memwrite_next = ctrl.id_memwrite_i;
      ex_memread_next  = ctrl.id_memread_i;
      ex_alusrc_next   = ctrl.id_alusrc_i;
      ex_aluop_next    = ctrl.id_aluop_i;
      ex_rd_next       = ctrl.id_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_regwrite_reg  <= 1'b0;
      ex_memwrite_reg  <= 1'b0;
      ex_memread_reg   <= 1'b0;
      ex_alusrc_reg    <= 1'b0;
      ex_aluop_reg     <= '0;
      ex_rd_reg        <= '0;
      mem_regwrite_reg <= 1'b0;
      mem_memwrite_reg <= 1'b0;
      mem_memread_reg  <= 1'b0;
      mem_rd_reg       <= '0;
      wb_regwrite_reg  <= 1'b0;
      wb_memtoreg_reg  <= 1'b0;
      wb_rd_reg        <= '0;
    end else begin
      ex_regwrite_reg  <= ex_regwrite_next;
      ex_memwrite_reg  <= ex_memwrite_next;
      ex_memread_reg   <= ex_memread_next;
      ex_alusrc_reg    <= ex_alusrc_next;
      ex_aluop_reg     <= ex_aluop_next;
      ex_rd_reg        <= ex_rd_next;
      mem_regwrite_reg <= ex_regwrite_reg;
      mem_memwrite_reg <= ex_memwrite_reg;
      mem_memread_reg  <= ex_memread_reg;
      mem_rd_reg       <= ex_rd_reg;
      wb_regwrite_reg  <= mem_regwrite_reg;
      wb_memtoreg_reg  <= mem_memread_reg;
      wb_rd_reg        <= mem_rd_reg;
    end
  end

  // A stalled branch keeps its ID slot, so its flush is simply deferred a cycle.
  assign ctrl.stall_o        = hazard;
  assign ctrl.flush_o        = ctrl.id_branch_taken_i & ~hazard;
  assign ctrl.ex_regwrite_o  = ex_regwrite_reg;
  assign ctrl.ex_memwrite_o  = ex_memwrite_reg;
  assign ctrl.ex_memread_o   = ex_memread_reg;
  assign ctrl.ex_alusrc_o    = ex_alusrc_reg;
  assign ctrl.ex_aluop_o     = ex_aluop_reg;
  assign ctrl.ex_rd_o        = ex_rd_reg;
  assign ctrl.mem_regwrite_o = mem_regwrite_reg;
  assign ctrl.mem_memwrite_o = mem_memwrite_reg;
  assign ctrl.mem_memread_o  = mem_memread_reg;
  assign ctrl.mem_rd_o       = mem_rd_reg;
  assign ctrl.wb_regwrite_o  = wb_regwrite_reg;
  assign ctrl.wb_memtoreg_o  = wb_memtoreg_reg;
  assign ctrl.wb_rd_o        = wb_rd_reg;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (ctrl.stall_o) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (ctrl.flush_o) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`endif
endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Table-driven bench for id_ex_ctrl_pipe: per-cycle vectors carry expected stall/flush,
// a scoreboard queue holds the expected EX bundle for each cycle and is replayed down MEM/WB.
module tb_id_ex_ctrl_pipe;
`ifdef CTRL_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       mr;
    logic       as;
    logic [2:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       br;
    logic       exp_stall;
    logic       exp_flush;
  } vec_t;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       mr;
    logic       as;
    logic [2:0] op;
    logic [4:0] rd;
  } exb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_ctrl_if #(.ALUOP_W(3), .REG_ADDR_W(5)) bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [CNT_W-1:0] exp_stall_cnt, exp_flush_cnt;
`endif

  id_ex_ctrl_pipe #(.ALUOP_W(3), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctrl  (bus)
`ifdef CTRL_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;
  exb_t exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL step=%0d %s actual=0x%0h required=0x%0h", step_no, name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic rw, mw, mr, as, input logic [2:0] op,
                              input logic [4:0] rs1, rs2, rd, input logic br, st, fl);
    vec_t v;
    v = '{rw: rw, mw: mw, mr: mr, as: as, op: op, rs1: rs1, rs2: rs2, rd: rd,
          br: br, exp_stall: st, exp_flush: fl};
    return v;
  endfunction

  task automatic compare_stages();
    exb_t e_ex, e_mem, e_wb;
    e_ex  = exp_q[exp_q.size()-1];
    e_mem = exp_q[exp_q.size()-2];
    e_wb  = exp_q[exp_q.size()-3];
    check("ex_bundle", {26'd0, bus.ex_regwrite_o, bus.ex_memwrite_o, bus.ex_memread_o,
                        bus.ex_alusrc_o, bus.ex_aluop_o, bus.ex_rd_o}, {26'd0, e_ex});
    check("mem_bundle", {bus.mem_regwrite_o, bus.mem_memwrite_o, bus.mem_memread_o, bus.mem_rd_o},
                        {e_mem.rw, e_mem.mw, e_mem.mr, e_mem.rd});
    check("wb_bundle", {bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_rd_o},
                       {e_wb.rw, e_wb.mr, e_wb.rd});
  endtask

  // One clock of stimulus: combinational outputs checked mid-cycle, registered outputs after the edge.
  task automatic step(input vec_t v, input logic do_rst);
    exb_t e;
    step_no++;
    rst = do_rst;
    if (do_rst) begin
      bus.id_regwrite_i = 1'($urandom); bus.id_memwrite_i = 1'($urandom);
      bus.id_memread_i = 1'($urandom);  bus.id_alusrc_i = 1'($urandom);
      bus.id_aluop_i = 3'($urandom);    bus.id_rs1_i = 5'($urandom);
      bus.id_rs2_i = 5'($urandom);      bus.id_rd_i = 5'($urandom);
      bus.id_branch_taken_i = 1'($urandom);
    end else begin
      bus.id_regwrite_i = v.rw;  bus.id_memwrite_i = v.mw; bus.id_memread_i = v.mr;
      bus.id_alusrc_i = v.as;    bus.id_aluop_i = v.op;    bus.id_rs1_i = v.rs1;
      bus.id_rs2_i = v.rs2;      bus.id_rd_i = v.rd;       bus.id_branch_taken_i = v.br;
    end
    @(negedge clk);
    if (!do_rst) begin
      check("stall_o", {31'd0, bus.stall_o}, {31'd0, v.exp_stall});
      check("flush_o", {31'd0, bus.flush_o}, {31'd0, v.exp_flush});
    end
    if (do_rst) begin
      exp_q = {};
      repeat (3) exp_q.push_back('0);
    end else begin
      e = v.exp_stall ? exb_t'('0) : exb_t'({v.rw, v.mw, v.mr, v.as, v.op, v.rd});
      exp_q.push_back(e);
      if (exp_q.size() > 3) void'(exp_q.pop_front());
    end
`ifdef CTRL_PERF_CNT_EN
    if (do_rst) begin
      exp_stall_cnt = '0;
      exp_flush_cnt = '0;
    end else begin
      exp_stall_cnt = exp_stall_cnt + CNT_W'(v.exp_stall);
      exp_flush_cnt = exp_flush_cnt + CNT_W'(v.exp_flush);
    end
`endif
    @(posedge clk);
    #1;
    compare_stages();
    if (do_rst) check("stall_after_rst", {31'd0, bus.stall_o}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(exp_stall_cnt));
    check("flush_cnt", 32'(flush_cnt), 32'(exp_flush_cnt));
`endif
    $display("step %0d rst=%0b id_rd=%0d stall=%0b ex_rd=%0d mem_rd=%0d wb_rd=%0d wb_m2r=%0b",
             step_no, do_rst, v.rd, v.exp_stall, bus.ex_rd_o, bus.mem_rd_o, bus.wb_rd_o,
             bus.wb_memtoreg_o);
  endtask

  vec_t lw5, dep5, dep5b, z;

  initial begin
    z = '0;
    // add rd1 / sw / lw rd2, then a run of hazard and boundary cases
    vecs.push_back(mk(1,0,0,0,3'd0,  2, 3, 1, 0, 0,0));
    vecs.push_back(mk(0,1,0,1,3'd0,  1, 4, 0, 0, 0,0));
    vecs.push_back(mk(1,0,1,1,3'd0,  3, 0, 2, 0, 0,0));
    vecs.push_back(mk(1,0,0,0,3'd1,  6, 7, 8, 0, 0,0));
    vecs.push_back(mk(1,0,1,1,3'd0,  1, 0, 5, 0, 0,0));
    vecs.push_back(mk(1,0,0,0,3'd2,  5, 6, 7, 0, 1,0));
    vecs.push_back(mk(1,0,0,0,3'd2,  5, 6, 7, 0, 0,0));
    vecs.push_back(mk(1,0,1,1,3'd0,  1, 0, 0, 0, 0,0));
    vecs.push_back(mk(1,0,0,0,3'd3,  0, 0, 3, 0, 0,0));
    vecs.push_back(mk(1,0,1,1,3'd0,  2, 0, 9, 0, 0,0));
    vecs.push_back(mk(0,0,0,0,3'd4,  9, 1, 0, 1, 1,0));
    vecs.push_back(mk(0,0,0,0,3'd4,  9, 1, 0, 1, 0,1));
    vecs.push_back(mk(1,0,1,1,3'd0,  2, 0, 4, 0, 0,0));
    vecs.push_back(mk(1,0,0,1,3'd5,  1, 4,12, 0, 1,0));
    vecs.push_back(mk(1,0,0,1,3'd5,  1, 4,12, 0, 0,0));
    vecs.push_back(mk(1,0,1,1,3'd0,  3, 0,10, 0, 0,0));
    vecs.push_back(mk(1,0,1,1,3'd0, 10, 0,11, 0, 1,0));
    vecs.push_back(mk(1,0,1,1,3'd0, 10, 0,11, 0, 0,0));
    vecs.push_back(mk(1,0,0,0,3'd6,  1,11,13, 0, 1,0));
    vecs.push_back(mk(1,0,0,0,3'd6,  1,11,13, 0, 0,0));
    vecs.push_back(mk(1,0,0,0,3'd7,  1, 2, 0, 0, 0,0));
    vecs.push_back(mk(0,0,0,0,3'd4,  3, 4, 0, 1, 0,1));

    bus.id_regwrite_i = 1'b0; bus.id_memwrite_i = 1'b0; bus.id_memread_i = 1'b0;
    bus.id_alusrc_i = 1'b0;   bus.id_aluop_i = '0;      bus.id_rs1_i = '0;
    bus.id_rs2_i = '0;        bus.id_rd_i = '0;         bus.id_branch_taken_i = 1'b0;

    step(z, 1'b1);
    step(z, 1'b1);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1'b0);
    repeat (3) step(mk(0,0,0,0,3'd0, 0,0,0, 0, 0,0), 1'b0);

    // Reset mid-stream drops the in-flight load, so its dependent no longer stalls.
    lw5   = mk(1,0,1,1,3'd0, 1,0,5, 0, 0,0);
    dep5  = mk(1,0,0,0,3'd2, 5,6,7, 0, 1,0);
    dep5b = mk(1,0,0,0,3'd2, 5,6,7, 0, 0,0);
    step(lw5, 1'b0);
    step(dep5, 1'b1);
    step(dep5b, 1'b0);

    // Seventeen forced stalls from a clean reset.
    step(z, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(lw5, 1'b0);
      step(dep5, 1'b0);
      step(dep5b, 1'b0);
    end
`ifdef CTRL_PERF_CNT_EN
    check("stall_cnt_wrap", 32'(stall_cnt), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
